fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the IF stage: owns the fetch PC, issues one instruction-memory
//  request at a time, and captures the returned word into a 2-entry IF output
//  buffer (output reg + skid) that honours decode back-pressure.
//  Applies redirects from EX (ALU target, steered through pc_sel) and squashes any
//  in-flight fetch. Sits between the fetch PC mux/instruction memory and decode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  MAX_WAIT  15             grant-to-rvalid cycle limit (timeout feature only)
//  WAIT_W    4              width of the wait counter; must hold MAX_WAIT
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   synchronous, active-high
//  i_redirect     in   1   EX taken branch/jump, single-cycle pulse
//  i_redirect_pc  in   32  redirect target (ALU output)
//  i_stall        in   1   decode not ready; hold o_if_* stable
//  o_imem_req     out  1   instruction-memory request
//  o_imem_addr    out  32  request address (current pc_q)
//  i_imem_gnt     in   1   request accepted this cycle
//  i_imem_rvalid  in   1   read data valid
//  i_imem_rdata   in   32  instruction word
//  o_pc_sel       out  1   fetch PC mux select: 1 = ALU target, 0 = pc+4
//  o_pc_we        out  1   fetch PC register write enable
//  o_if_valid     out  1   IF/ID entry valid
//  o_if_pc        out  32  PC of o_if_inst
//  o_if_inst      out  32  fetched instruction
//  o_fault        out  1   fetch timeout, sticky (FETCH_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset:
//   - pc_q = RESET_PC; state = IDLE; kill = 0; skid empty.
//   - All outputs are 0 except o_imem_addr, which is RESET_PC.
//   - Reset mid-WAIT discards the outstanding response. The first rvalid after
//     reset release is ignored unless a request has since been granted.
//  Pipeline and request states:
//   - IDLE: exactly 1 cycle after reset deasserts, then REQ. No request is issued.
//   - REQ:
//     - o_imem_req = 1 and o_imem_addr = pc_q, unless both the output reg and the
//       skid are full; in that case o_imem_req = 0.
//     - o_imem_addr is held stable until i_imem_gnt.
//     - The grant moves the FSM to WAIT. One request is outstanding at most.
//   - WAIT:
//     - On i_imem_rvalid with kill = 1: drop the data, clear kill, return to REQ.
//     - Otherwise the word goes to the output reg when that reg is empty or
//       !i_stall; else it goes to the skid.
//     - Then pc_q <= pc_q + 4, o_pc_we = 1, o_pc_sel = 0, FSM -> REQ.
//   - HOLD: entered when the skid is full and the output reg is stalled. It moves to
//     REQ in the cycle i_stall = 0 (skid -> output reg).
//  Latency: grant to rvalid to o_if_valid = 1 cycle. Best-case throughput is
//   1 instruction per 2 cycles (REQ, WAIT) with a 1-cycle memory.
//  Redirect (highest priority, any state except IDLE):
//   - pc_q <= {i_redirect_pc[31:2], 2'b00}; o_pc_sel = 1 and o_pc_we = 1 that cycle.
//   - Output reg and skid are invalidated next cycle (o_if_valid = 0).
//   - In WAIT without rvalid: set kill; the FSM stays in WAIT.
//   - In WAIT with rvalid in the same cycle: drop the data; FSM -> REQ.
//   - In REQ with gnt in the same cycle: set kill; FSM -> WAIT.
//   - In REQ without gnt or in HOLD: FSM -> REQ. The new address is driven the
//     next cycle.
//   - A redirect and a completing fetch in the same cycle: the redirect wins;
//     pc+4 is not applied.
//  Other rules:
//   - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
//   - An rvalid while not in WAIT is ignored.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   - A WAIT_W-bit counter clears on grant and increments each WAIT cycle without
//     rvalid.
//   - When the count reaches MAX_WAIT: o_fault <= 1 (sticky until reset); FSM ->
//     FAULT. FAULT issues no requests and ignores redirects; o_if_valid is forced 0.
//  FETCH_TIMEOUT_EN undefined:
//   - There is no counter and no FAULT state; o_fault is tied 0.
//   - WAIT waits indefinitely.
// TESTING
//  1. Reset, then gnt/rvalid on the cycle after each request. Expect addr sequence
//     0,4,8,12. o_if_pc tracks addr; o_pc_we pulses once per fetch.
//  2. i_stall=1 for 6 cycles after the first valid. o_if_inst stays stable and the
//     skid fills. o_imem_req stays 0 with both entries full. Release: order is kept.
//  3. i_redirect with target 32'h100 while in WAIT, rvalid 2 cycles later.
//     Expect the late word dropped, the next addr 32'h100, and o_pc_sel=1 for 1 cycle.
//  4. Redirect and rvalid in the same cycle, target 32'h203. Expect the word dropped
//     and next addr 32'h200.
//  5. reset asserted mid-WAIT. Expect all outputs zero and a fresh fetch at RESET_PC.
//  6. FETCH_TIMEOUT_EN: grant with no rvalid. o_fault=1 exactly MAX_WAIT cycles after
//     the grant; no further o_imem_req.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer with a 2-entry output buffer; FETCH_TIMEOUT_EN adds a grant-to-rvalid timeout
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15,
  parameter int          WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_pc_sel,
  output logic        o_pc_we,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_inst,
  output logic        o_fault
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
`ifdef FETCH_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;
  state_t      r_state, w_nx;
  logic        r_kill, w_kill_nx;
  logic [31:0] r_pc;
  logic        r_out_v, r_sk_v;
  logic [31:0] r_out_pc, r_out_inst, r_sk_pc, r_sk_inst;
  logic        w_full, w_pop, w_redir, w_gnt, w_take, w_to_out, w_to_sk, w_timeout;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [WAIT_W:0]   LP_MAX  = (WAIT_W+1)'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] LP_MAXC = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W:0]   w_cnt_inc;
  logic              r_fault;
  assign w_cnt_inc  = {1'b0, r_cnt} + {{WAIT_W{1'b0}}, 1'b1};
  assign w_redir    = i_redirect & (r_state != S_IDLE) & (r_state != S_FAULT);
  assign o_if_valid = r_out_v & (r_state != S_FAULT);
  assign o_fault    = r_fault;
`else
  assign w_redir    = i_redirect & (r_state != S_IDLE);
  assign o_if_valid = r_out_v;
  assign o_fault    = 1'b0;
`endif
  assign w_full      = r_out_v & r_sk_v;
  assign w_pop       = o_if_valid & ~i_stall;
  assign o_imem_req  = (r_state == S_REQ) & ~w_full;
  assign o_imem_addr = r_pc;
  assign w_gnt       = o_imem_req & i_imem_gnt;
  assign w_take      = (r_state == S_WAIT) & i_imem_rvalid & ~r_kill & ~w_redir;
  assign w_to_out    = w_take & (~r_out_v | ~i_stall);
  assign w_to_sk     = w_take & ~w_to_out;
  assign o_pc_sel    = w_redir;
  assign o_pc_we     = w_redir | w_take;
  assign o_if_pc     = r_out_pc;
  assign o_if_inst   = r_out_inst;
  // next state and kill flag; a redirect with a grant leaves a response that must be dropped
  always_comb begin
    w_nx      = r_state;
    w_kill_nx = r_kill;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: w_nx = S_REQ;
      S_REQ: begin
        if (w_gnt) begin
          w_nx      = S_WAIT;
          w_kill_nx = w_redir;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          w_nx      = w_to_sk ? S_HOLD : S_REQ;
          w_kill_nx = 1'b0;
        end else if (w_redir) begin
          w_kill_nx = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (w_cnt_inc >= LP_MAX) begin
          w_nx      = S_FAULT;
          w_timeout = 1'b1;
        end
`endif
      end
      S_HOLD: w_nx = (~i_stall | w_redir) ? S_REQ : S_HOLD;
      default: ;
    endcase
  end
  // state, kill flag and fetch PC (redirect target is word-aligned, pc+4 wraps mod 2^32)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_kill  <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_nx;
      r_kill  <= w_kill_nx;
      if (o_pc_we) r_pc <= o_pc_sel ? (i_redirect_pc & ~32'd3) : r_pc + 32'd4;
    end
  end
  // output reg plus skid; the skid is always empty while a fetch is outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_v    <= 1'b0;
      r_sk_v     <= 1'b0;
      r_out_pc   <= '0;
      r_out_inst <= '0;
      r_sk_pc    <= '0;
      r_sk_inst  <= '0;
    end else if (w_redir) begin
      r_out_v <= 1'b0;
      r_sk_v  <= 1'b0;
    end else begin
      if (w_to_out) begin
        r_out_v    <= 1'b1;
        r_out_pc   <= r_pc;
        r_out_inst <= i_imem_rdata;
      end else if (w_pop) begin
        r_out_v    <= r_sk_v;
        r_out_pc   <= r_sk_pc;
        r_out_inst <= r_sk_inst;
        r_sk_v     <= 1'b0;
      end
      if (w_to_sk) begin
        r_sk_v    <= 1'b1;
        r_sk_pc   <= r_pc;
        r_sk_inst <= i_imem_rdata;
      end
    end
  end
`ifdef FETCH_TIMEOUT_EN
  // wait counter restarts on grant and saturates; fault is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_gnt) r_cnt <= '0;
      else if (r_state == S_WAIT && !i_imem_rvalid && r_cnt != LP_MAXC) r_cnt <= w_cnt_inc[WAIT_W-1:0];
      if (w_timeout) r_fault <= 1'b1;
    end
  end
`endif
endmodule
